// File: rtl/adc_pkg.sv
// Shared ADC definitions used by the SPI poller and its post-processing stages.
package adc_pkg;

  localparam int ADC_DATA_W = 12;
  localparam int ADC_CH_N   = 8;

  typedef logic [2:0]  adc_ch_t;
  typedef logic [11:0] adc_sample_t;

  // Parity of a sample word; handy for integrity checks on stored results.
  function automatic logic sample_parity(input adc_sample_t v);
    return ^v;
  endfunction

endpackage

// File: rtl/adc_channel_averager_if.sv
// Channel-tagged sample stream: valid/ready handshake with channel and data.
interface adc_channel_averager_if #(
  parameter int CH_W   = 3,
  parameter int DATA_W = 12
);
  logic              valid;
  logic              ready;
  logic [CH_W-1:0]   ch;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ch, output data, input ready);
  modport slave  (input valid, input ch, input data, output ready);
endinterface

// File: rtl/adc_avg_out_reg.sv
// One-entry valid/ready holding register. A new result arriving while the
// held one is still waiting is dropped and flagged in a sticky overflow bit.
module adc_avg_out_reg
  import adc_pkg::*;
#(
  parameter int CH_W   = 3,
  parameter int DATA_W = ADC_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  input  logic              ovf_clr,
  output logic              ovf,
  adc_channel_averager_if.master m
);

  logic              valid_q, valid_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ovf_q, ovf_d;
  logic              accept_s;

  assign accept_s = valid_q & m.ready;

  // Next state: load when empty or draining this cycle, otherwise drop.
  always_comb begin
    valid_d = valid_q;
    ch_d    = ch_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    if (in_valid && (!valid_q || accept_s)) begin
      valid_d = 1'b1;
      ch_d    = in_ch;
      data_d  = in_data;
    end else if (in_valid) begin
      ovf_d   = 1'b1;
    end else if (accept_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    // A drop in the same cycle as a clear keeps the flag set.
    if (ovf_clr && !(in_valid && valid_q && !accept_s)) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_d;
    end
  end

  // Output and overflow state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ch_q    <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      ch_q    <= ch_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign m.valid = valid_q;
  assign m.ch    = ch_q;
  assign m.data  = data_q;
  assign ovf     = ovf_q;

endmodule

// File: rtl/adc_channel_averager.sv
// Per-channel boxcar averager: accumulates 2^AVG_LOG2 samples per channel,
// presents each average on a one-deep output and keeps the last one per channel.
module adc_channel_averager
  import adc_pkg::*;
#(
  parameter int AVG_LOG2 = 3,
  parameter int DATA_W   = ADC_DATA_W,
  parameter int CH_N     = ADC_CH_N,
  localparam int CH_W    = $clog2(CH_N)
) (
  input  logic              clk,
  input  logic              rst,
  adc_channel_averager_if.slave  s,
  adc_channel_averager_if.master m,
  output logic              ovf,
  input  logic              ovf_clr,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [DATA_W-1:0] rd_data
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  // Keep the counter at least one bit wide so passthrough stays legal.
  localparam int CNT_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0]  acc_q  [CH_N];
  logic [ACC_W-1:0]  acc_d  [CH_N];
  logic [CNT_W-1:0]  cnt_q  [CH_N];
  logic [CNT_W-1:0]  cnt_d  [CH_N];
  logic [DATA_W-1:0] last_q [CH_N];
  logic [DATA_W-1:0] last_d [CH_N];

  logic              complete_s;
  logic [ACC_W-1:0]  sum_s;
  logic [DATA_W-1:0] avg_s;

  // Samples are never refused.
  assign s.ready    = 1'b1;
  assign complete_s = s.valid && (cnt_q[s.ch] == CNT_MAX);
  assign sum_s      = acc_q[s.ch] + ACC_W'(s.data);
  assign avg_s      = DATA_W'(sum_s >> AVG_LOG2);
  assign rd_data    = last_q[rd_ch];

  // Accumulate the addressed channel, or close out its average window.
  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    if (complete_s) begin
      acc_d[s.ch]  = '0;
      cnt_d[s.ch]  = '0;
      last_d[s.ch] = avg_s;
    end else if (s.valid) begin
      acc_d[s.ch]  = sum_s;
      cnt_d[s.ch]  = cnt_q[s.ch] + CNT_W'(1);
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator, count and result-bank registers; reset discards partials.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH_N; i++) begin
        acc_q[i]  <= '0;
        cnt_q[i]  <= '0;
        last_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH_N; i++) begin
        acc_q[i]  <= acc_d[i];
        cnt_q[i]  <= cnt_d[i];
        last_q[i] <= last_d[i];
      end
    end
  end

  adc_avg_out_reg #(
    .CH_W  (CH_W),
    .DATA_W(DATA_W)
  ) u_out (
    .clk     (clk),
    .rst     (rst),
    .in_valid(complete_s),
    .in_ch   (s.ch),
    .in_data (avg_s),
    .ovf_clr (ovf_clr),
    .ovf     (ovf),
    .m       (m)
  );

endmodule

// File: doc/adc_channel_averager.md
Name: adc_channel_averager

Overview:
Downstream consumer of the SPI ADC poller. Takes channel-tagged 12-bit samples and keeps a per-channel accumulator for each of the 8 inputs (IN0-IN7). Every 2^AVG_LOG2 samples on a channel, it emits a boxcar average for that channel.
Results go out through a one-deep valid/ready output. The last average of every channel is also held in a readable register bank.

Parameters:
AVG_LOG2, 3, log2 of samples averaged per channel (0 = passthrough; legal range 0..4)
DATA_W, 12, sample width (ADC result width)
CH_N, 8, number of ADC channels; channel index width = $clog2(CH_N)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  reset, asynchronous, active-high
s_valid  in  1  sample strobe from poller, one cycle per completed conversion
s_ch  in  3  channel (address) the sample belongs to
s_data  in  12  sample value
m_valid  out  1  average available
m_ready  in  1  consumer accepts average when high with m_valid
m_ch  out  3  channel of presented average
m_data  out  12  presented average
ovf  out  1  sticky: a completed average could not be presented (output occupied)
ovf_clr  in  1  clears ovf
rd_ch  in  3  register-bank read select
rd_data  out  12  last completed average of channel rd_ch (combinational read)

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - acc[0..7], cnt[0..7], last[0..7] = 0
  - m_valid = 0, m_ch = 0, m_data = 0, ovf = 0
  - Partial accumulations are discarded on reset mid-operation.
- Input side:
  - s_valid is never back-pressured; every strobe is accepted.
  - Samples of one channel need not be contiguous; channels interleave freely.
- Accumulator:
  - acc[ch] is DATA_W+AVG_LOG2 bits wide, so it cannot overflow.
  - cnt[ch] is AVG_LOG2 bits wide.
  - On s_valid with cnt[s_ch] != 2^AVG_LOG2-1: acc[s_ch] += s_data, cnt[s_ch]++.
- Completion, on s_valid with cnt[s_ch] == 2^AVG_LOG2-1:
  - avg = (acc[s_ch] + s_data) >> AVG_LOG2, truncating with no rounding.
  - acc[s_ch] <= 0, cnt[s_ch] <= 0.
  - last[s_ch] <= avg.
  - AVG_LOG2 = 0: every sample completes and avg = s_data.
- Latency: a completing sample at cycle k gives m_valid = 1, m_ch, m_data at cycle k+1. last[] also updates at k+1.
- Output register (valid/ready):
  - Holds until accepted (m_valid & m_ready); m_ch and m_data are stable while m_valid & !m_ready.
  - Completion while output empty, or while being accepted the same cycle: load the new result; no bubble.
  - Completion while m_valid & !m_ready:
    - The new result is dropped from the output and the held result is kept.
    - ovf <= 1.
    - last[] is still updated.
  - Acceptance without completion: m_valid <= 0; m_data and m_ch keep their values.
- ovf: set by drop, cleared by ovf_clr. If set and ovf_clr occur the same cycle, set wins.
- rd_data = last[rd_ch], purely combinational. A read the same cycle last[] is written returns the old value.

Decomposition:
- Shared package adc_pkg:
  - ADC_DATA_W = 12, ADC_CH_N = 8
  - typedef adc_ch_t (logic [2:0]), typedef adc_sample_t (logic [11:0])
  - The poller and this block both import it.
- One natural sub-module: adc_avg_out_reg. It is the one-entry valid/ready holding register with drop/overflow-flag logic, reusable for other ADC post-processing stages.
- Accumulator and count arrays stay in the top module.

Test Plan:
1. Reset check:
   - Stimulus: assert rst mid-run, then sweep rd_ch 0..7.
   - Response: m_valid=0, ovf=0, m_data=0, rd_data=0 for all channels.
2. Single-channel average:
   - Stimulus: AVG_LOG2=2; ch3 samples 100, 200, 300, 401.
   - Response: exactly one m_valid, the cycle after the 4th strobe; m_ch=3, m_data=250; rd_data(ch3)=250.
3. Interleave and full scale:
   - Stimulus: AVG_LOG2=2; alternate ch0 samples 0xFFF x4 with ch7 samples 1, 0, 0, 0.
   - Response: ch0 gives 4095; ch7 gives 0; results emerge in completion order.
4. Backpressure and ovf:
   - Stimulus: m_ready=0; complete ch1 (avg 10), then ch2 (avg 20).
   - Response: m_data stays 10 with m_ch=1; ovf=1; rd_data(ch2)=20.
   - Then pulse ovf_clr together with another drop: ovf stays 1. Pulse ovf_clr alone: ovf becomes 0.
5. No-bubble handoff:
   - Stimulus: m_ready=1; ch4 completes at cycle k, ch5 completes at cycle k+1.
   - Response: m_valid is high for cycles k+1 and k+2, carrying ch4 then ch5.
6. Reset mid-accumulation and passthrough:
   - Stimulus: AVG_LOG2=2; 2 samples of 500 on ch5, then rst, then 4 samples of 8 on ch5.
   - Response: m_data=8.
   - Separately, AVG_LOG2=0: each sample reappears one cycle later unchanged.
